// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared MFCC front-end constants and window FSM state type
package mfcc_pkg;
    localparam int WIDTH      = 16;
    localparam int COEF_WIDTH = 16;
    localparam int FRAME_SIZE = 306;
    localparam int MOVE_SIZE  = 123;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        DONE
    } win_state_e;
endpackage

// File: rtl/hamming_rom.sv
// rtl/hamming_rom.sv - Hamming window coefficient ROM, unsigned Q1.15, 1-cycle read latency
module hamming_rom #(
    parameter int DEPTH      = 306,
    parameter int COEF_WIDTH = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [AW-1:0]         i_addr,
    output logic [COEF_WIDTH-1:0] o_coef
);
    localparam real PI = 3.141592653589793;

    logic [COEF_WIDTH-1:0] w_tab [DEPTH];
    logic [COEF_WIDTH-1:0] r_coef;

    // Table is folded to constants at elaboration; +0.5 rounds the always-positive value
    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        assign w_tab[g] = COEF_WIDTH'($rtoi(32767.0 * (0.54 - 0.46 * $cos(2.0 * PI * g / (DEPTH - 1))) + 0.5));
    end

    always_ff @(posedge clk) begin
        r_coef <= w_tab[i_addr];
    end

    assign o_coef = r_coef;
endmodule

// File: rtl/hamming_window.sv
// rtl/hamming_window.sv - applies the Hamming window to one frame read from the window buffer
module hamming_window #(
    parameter int WIDTH      = mfcc_pkg::WIDTH,
    parameter int FRAME_SIZE = mfcc_pkg::FRAME_SIZE,
    parameter int COEF_WIDTH = mfcc_pkg::COEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic             wb_rd_en_o,
    input  logic [WIDTH-1:0] wb_data_i,
    input  logic             wb_valid_i,
    output logic             start_move_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             busy_o
);
    import mfcc_pkg::*;

    localparam int NW = $clog2(FRAME_SIZE);
    localparam int PW = WIDTH + COEF_WIDTH + 1;
    localparam int SH = COEF_WIDTH - 1;
    localparam logic [NW-1:0]        LAST_N = NW'(FRAME_SIZE - 1);
    localparam logic signed [PW-1:0] RND    = PW'(1 << (SH - 1));
    localparam logic signed [PW-1:0] SAT_HI = PW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] SAT_LO = PW'(-(64'sd1 <<< (WIDTH - 1)));

    win_state_e             r_state;
    logic [NW-1:0]          r_n;
    logic                   r_rd_en;
    logic                   r_move;
    logic                   r_valid;
    logic                   r_last;
    logic                   r_busy;
    logic [WIDTH-1:0]       r_data;

    logic [COEF_WIDTH-1:0]  w_coef;
    logic signed [PW-1:0]   w_data_x;
    logic signed [PW-1:0]   w_coef_x;
    logic signed [PW-1:0]   w_prod;
    logic signed [PW-1:0]   w_shift;
    logic [WIDTH-1:0]       w_sat;

    // n is held through REQ, so the ROM word is ready by the first WAIT cycle
    hamming_rom #(
        .DEPTH      (FRAME_SIZE),
        .COEF_WIDTH (COEF_WIDTH),
        .AW         (NW)
    ) u_rom (
        .clk    (clk),
        .i_addr (r_n),
        .o_coef (w_coef)
    );

    // Coefficient is unsigned, so it gets a zero sign bit before the signed multiply
    assign w_data_x = PW'($signed(wb_data_i));
    assign w_coef_x = PW'($signed({1'b0, w_coef}));
    assign w_prod   = w_data_x * w_coef_x;
    assign w_shift  = (w_prod + RND) >>> SH;

    always_comb begin
        w_sat = w_shift[WIDTH-1:0];
        if (w_shift > SAT_HI) begin
            w_sat = SAT_HI[WIDTH-1:0];
        end else if (w_shift < SAT_LO) begin
            w_sat = SAT_LO[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_rd_en <= 1'b0;
            r_move  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_rd_en <= 1'b0;
            r_move  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= REQ;
                        r_n     <= '0;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                REQ: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (wb_valid_i) begin
                        r_state <= OUT;
                        r_data  <= w_sat;
                        r_valid <= 1'b1;
                        r_last  <= (r_n == LAST_N);
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_n == LAST_N) begin
                            r_state <= DONE;
                            r_move  <= 1'b1;
                        end else begin
                            r_n     <= r_n + 1'b1;
                            r_state <= REQ;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wb_rd_en_o   = r_rd_en;
    assign start_move_o = r_move;
    assign out_data_o   = r_data;
    assign out_valid_o  = r_valid;
    assign out_last_o   = r_last;
    assign busy_o       = r_busy;
endmodule
